pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the EX/IF boundary. It owns the PC register and selects the next fetch address from sequential, branch, jump-register, absolute-jump, halt or return sources. It adds a hardware return-address stack with push-on-call, pop-on-return and overflow/underflow detection. It takes over from the purely combinational next-address mux, so downstream fetch logic reads a registered PC instead of rebuilding one.

---
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: registered PC, next-address selection and a
// circular return-address stack with overflow/underflow detection.
module pc_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int STACK_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [2:0]            pc_select,
  input  logic [ADDR_WIDTH-1:0] branch_address,
  input  logic [ADDR_WIDTH-1:0] jr_address,
  input  logic [ADDR_WIDTH-1:0] jpc_address,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus1,
  output logic [ADDR_WIDTH-1:0] next_address,
  output logic [ADDR_WIDTH-1:0] stack_top,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  halted,
  output logic                  stack_error
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(STACK_DEPTH);

  localparam logic [2:0] SEL_RET    = 3'b000;
  localparam logic [2:0] SEL_JR     = 3'b001;
  localparam logic [2:0] SEL_BRANCH = 3'b011;
  localparam logic [2:0] SEL_HALT   = 3'b100;
  localparam logic [2:0] SEL_JPC    = 3'b101;
  localparam logic [2:0] SEL_CALL   = 3'b110;

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]      top_ptr;
  logic [PTR_W:0]        count;
  logic                  push;
  logic                  pop;
  logic                  underflow;
  logic                  commit;

  assign commit      = !reset && !stall;
  assign pc_plus1    = pc + 1'b1;
  assign stack_empty = (count == '0);
  assign stack_full  = (count == DEPTH_CNT);
  // Stale entries below the live region are never shown once the count is zero.
  assign stack_top   = stack_empty ? '0 : stack_mem[top_ptr];

  always_comb begin
    next_address = pc_plus1;
    push         = 1'b0;
    pop          = 1'b0;
    underflow    = 1'b0;
    case (pc_select)
      SEL_RET: begin
        if (stack_empty) begin
          next_address = pc;
          underflow    = 1'b1;
        end else begin
          next_address = stack_top;
          pop          = 1'b1;
        end
      end
      SEL_JR:     next_address = jr_address;
      SEL_BRANCH: next_address = branch_address;
      SEL_HALT:   next_address = pc;
      SEL_JPC:    next_address = jpc_address;
      SEL_CALL: begin
        next_address = jpc_address;
        push         = 1'b1;
      end
      default:    next_address = pc_plus1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_ADDR;
      top_ptr     <= '0;
      count       <= '0;
      halted      <= 1'b0;
      stack_error <= 1'b0;
    end else if (!stall) begin
      pc     <= next_address;
      halted <= (pc_select == SEL_HALT);
      if (push) begin
        top_ptr <= top_ptr + 1'b1;
        // A push onto a full stack overwrites the oldest entry.
        if (stack_full) stack_error <= 1'b1;
        else            count <= count + 1'b1;
      end else if (pop) begin
        top_ptr <= top_ptr - 1'b1;
        count   <= count - 1'b1;
      end
      if (underflow) stack_error <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (commit && push) stack_mem[top_ptr + 1'b1] <= pc_plus1;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (32-bit, 4-entry stack).
module tb_pc_sequencer;

  localparam logic [2:0] RET = 3'b000, JR = 3'b001, NPC = 3'b010, BRANCH = 3'b011;
  localparam logic [2:0] HALT = 3'b100, JPC = 3'b101, CALL = 3'b110, RSVD = 3'b111;

  logic        clock = 1'b0;
  logic        reset, stall;
  logic [2:0]  pc_select;
  logic [31:0] branch_address, jr_address, jpc_address;
  logic [31:0] pc, pc_plus1, next_address, stack_top;
  logic        stack_empty, stack_full, halted, stack_error;

  int passed = 0;
  int total  = 0;

  pc_sequencer #(.ADDR_WIDTH(32), .STACK_DEPTH(4), .RESET_ADDR(32'h0)) dut (
    .clock(clock), .reset(reset), .stall(stall), .pc_select(pc_select),
    .branch_address(branch_address), .jr_address(jr_address),
    .jpc_address(jpc_address), .pc(pc), .pc_plus1(pc_plus1),
    .next_address(next_address), .stack_top(stack_top),
    .stack_empty(stack_empty), .stack_full(stack_full),
    .halted(halted), .stack_error(stack_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a select, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [2:0] sel);
    pc_select = sel;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b1; pc_select = NPC;
    branch_address = 32'h400; jr_address = 32'h500; jpc_address = 32'h300;

    // Reset, with stall also high
    step(NPC);
    check("rst_pc", pc, 32'h0);
    check("rst_empty", stack_empty, 1'b1);
    check("rst_full", stack_full, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_err", stack_error, 1'b0);
    check("rst_top", stack_top, 32'h0);
    reset = 1'b0; stall = 1'b0;
    #1;
    check("rst_next", next_address, 32'h1);
    for (int i = 1; i <= 3; i++) begin
      step(NPC);
      check("npc_seq", pc, 32'(i));
    end

    // Plain source selection
    step(JR);      check("jr_pc", pc, 32'h500);
    step(BRANCH);  check("branch_pc", pc, 32'h400);
    jpc_address = 32'h10;
    step(JPC);     check("jpc_pc", pc, 32'h10);

    // Nested call / return
    jpc_address = 32'h100;
    step(CALL);    check("call1_pc", pc, 32'h100); check("call1_top", stack_top, 32'h11);
    jpc_address = 32'h200;
    step(CALL);    check("call2_pc", pc, 32'h200); check("call2_top", stack_top, 32'h101);
    pc_select = RET; #1;
    check("ret_next", next_address, 32'h101);
    step(RET);     check("ret1_pc", pc, 32'h101); check("ret1_top", stack_top, 32'h11);
    step(RET);     check("ret2_pc", pc, 32'h11);
    check("ret2_empty", stack_empty, 1'b1);
    check("ret2_err", stack_error, 1'b0);

    // Stall and halt
    stall = 1'b1; branch_address = 32'h55; pc_select = BRANCH; #1;
    check("stall_next", next_address, 32'h55);
    step(BRANCH);  check("stall_pc", pc, 32'h11);
    jpc_address = 32'h300;
    step(CALL);    check("stall_call_pc", pc, 32'h11); check("stall_call_empty", stack_empty, 1'b1);
    stall = 1'b0;
    step(BRANCH);  check("unstall_pc", pc, 32'h55);
    for (int i = 0; i < 3; i++) begin
      step(HALT);
      check("halt_pc", pc, 32'h55);
      check("halt_flag", halted, 1'b1);
    end
    step(NPC);     check("resume_pc", pc, 32'h56); check("resume_halted", halted, 1'b0);
    step(RSVD);    check("rsvd_pc", pc, 32'h57);

    // Underflow is sticky until reset
    jpc_address = 32'h20;
    step(JPC);     check("uf_setup_pc", pc, 32'h20);
    step(RET);     check("uf_pc", pc, 32'h20); check("uf_err", stack_error, 1'b1);
    check("uf_empty", stack_empty, 1'b1);
    step(NPC); step(NPC);
    check("uf_sticky_pc", pc, 32'h22); check("uf_sticky_err", stack_error, 1'b1);
    reset = 1'b1; step(NPC); reset = 1'b0;
    check("uf_clear_err", stack_error, 1'b0); check("uf_clear_pc", pc, 32'h0);

    // Overflow: five calls to 0x40 from pc=0
    jpc_address = 32'h40;
    for (int i = 0; i < 4; i++) step(CALL);
    check("ov4_full", stack_full, 1'b1); check("ov4_err", stack_error, 1'b0);
    step(CALL);
    check("ov5_full", stack_full, 1'b1); check("ov5_err", stack_error, 1'b1);
    check("ov5_top", stack_top, 32'h41);
    for (int i = 0; i < 4; i++) begin
      step(RET);
      check("ov_ret_pc", pc, 32'h41);
    end
    check("ov_ret_empty", stack_empty, 1'b1);
    step(RET);     check("ov_uf_pc", pc, 32'h41);

    // Overflow with distinct return addresses: oldest (0x1) is lost
    reset = 1'b1; step(NPC); reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      jpc_address = 32'(i * 16);
      step(CALL);
    end
    check("ovd_pc", pc, 32'h50); check("ovd_err", stack_error, 1'b1);
    for (int i = 4; i >= 1; i--) begin
      step(RET);
      check("ovd_ret_pc", pc, 32'(i * 16 + 1));
      check("ovd_ret_full", stack_full, 1'b0);
    end
    check("ovd_empty", stack_empty, 1'b1);
    step(RET);     check("ovd_uf_pc", pc, 32'h11);

    // Reset mid-sequence discards the stack and overrides stall
    reset = 1'b1; step(NPC); reset = 1'b0;
    jpc_address = 32'h60;
    step(CALL); step(CALL);
    check("mid_top", stack_top, 32'h61);
    reset = 1'b1; stall = 1'b1;
    step(CALL);
    reset = 1'b0; stall = 1'b0;
    check("mid_pc", pc, 32'h0); check("mid_empty", stack_empty, 1'b1);
    check("mid_top0", stack_top, 32'h0);

    // Address wrap
    jpc_address = 32'hFFFF_FFFF;
    step(JPC);     check("wrap_pc", pc, 32'hFFFF_FFFF); check("wrap_plus1", pc_plus1, 32'h0);
    step(NPC);     check("wrap_npc", pc, 32'h0);
    step(JPC);
    jpc_address = 32'h5;
    step(CALL);    check("wrap_call_pc", pc, 32'h5); check("wrap_call_top", stack_top, 32'h0);
    check("wrap_call_empty", stack_empty, 1'b0);
    step(RET);     check("wrap_ret_pc", pc, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
